// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU core.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_ABS = 3'b110,
    OP_PRE = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam op_e RESET_OP = OP_ADD;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, DATA_W cycles per divide.
module alu_div_iter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem,
  output logic              dz
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] quo_q, rem_q, div_q;
  logic [DATA_W:0]   trial, diff;
  logic              fits;
  logic [DATA_W-1:0] rem_n, quo_n;

  // Partial remainder stays below the divisor, so the MSB of the trial
  // difference is a clean borrow flag; with a zero divisor every step fits,
  // leaving quo all ones and rem equal to the dividend.
  assign trial = {rem_q, quo_q[DATA_W-1]};
  assign diff  = trial - {1'b0, div_q};
  assign fits  = ~diff[DATA_W];
  assign rem_n = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_n = {quo_q[DATA_W-2:0], fits};

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(DATA_W - 1));
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = (div_q == '0);

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= a;
      rem_q  <= '0;
      div_q  <= b;
    end else if (busy_q) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: valid/ready input, 1-cycle ops, iterative divide, PRE replay.
// Optional ALU_SAT_EN: saturating ADD and zero-clamped SUB/NOT.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk_p_i,
  input  logic                reset_n_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DATA_W-1:0]   data_a_i,
  input  logic [DATA_W-1:0]   data_b_i,
  input  logic [2:0]          inst_i,
  output logic                valid_o,
  output logic [2*DATA_W-1:0] data_o,
  output logic                err_o
);

  localparam int W2 = 2 * DATA_W;

  fsm_e          state, state_n;
  op_e           inst, op_eff, last_op;
  logic          acc, is_div;
  logic [W2-1:0] a_x, b_x, sum, diff, sub_v, res;
  logic          b_ge_a;
  logic [W2-1:0] data_q;
  logic          err_q, vld_q;
  logic          div_busy, div_done, div_dz;
  logic [DATA_W-1:0] div_quo, div_rem;

  assign inst   = op_e'(inst_i);
  assign op_eff = (inst == OP_PRE) ? last_op : inst;
  assign is_div = (op_eff == OP_DIV);
  assign acc    = valid_i & ready_o;

  alu_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk_p_i  (clk_p_i),
    .reset_n_i(reset_n_i),
    .start    (acc & is_div),
    .a        (data_a_i),
    .b        (data_b_i),
    .busy     (div_busy),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem),
    .dz       (div_dz)
  );

  assign a_x    = {{DATA_W{1'b0}}, data_a_i};
  assign b_x    = {{DATA_W{1'b0}}, data_b_i};
  assign sum    = a_x + b_x;
  assign diff   = b_x - a_x;
  assign b_ge_a = (data_b_i >= data_a_i);

`ifdef ALU_SAT_EN
  assign sub_v = b_ge_a ? diff : '0;
`else
  assign sub_v = diff;
`endif

  always_comb begin
    res = '0;
    case (op_eff)
`ifdef ALU_SAT_EN
      OP_ADD: res = (|sum[W2-1:DATA_W]) ? {{DATA_W{1'b0}}, {DATA_W{1'b1}}} : sum;
`else
      OP_ADD: res = sum;
`endif
      OP_SUB: res = sub_v;
      OP_MUL: res = a_x * b_x;
      OP_NOT: res = ~sub_v;
      OP_XOR: res = a_x ^ b_x;
      OP_ABS: res = b_ge_a ? diff : (a_x - b_x);
      default: res = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_n;
  end

  // FSM: next state; DONE also accepts, so a new op can start as a divide retires
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = (acc && is_div) ? CALC : IDLE;
      CALC:       state_n = div_done ? DONE : CALC;
      default:    state_n = IDLE;
    endcase
  end

  // FSM: outputs; the divide result is shown live in DONE and captured on exit
  always_comb begin
    ready_o = (state != CALC);
    valid_o = vld_q | (state == DONE);
    data_o  = (state == DONE) ? {div_rem, div_quo} : data_q;
    err_o   = (state == DONE) ? div_dz : err_q;
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_op <= RESET_OP;
      data_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= acc & ~is_div;
      if (acc && inst != OP_PRE) last_op <= inst;
      if (acc && !is_div) begin
        data_q <= res;
        err_q  <= 1'b0;
      end else if (state == DONE) begin
        data_q <= {div_rem, div_quo};
        err_q  <= div_dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core (DATA_W=8); honours ALU_SAT_EN.
module tb_alu_seq_core;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  a, b;
  logic [2:0]  inst;
  logic        valid_o;
  logic [15:0] data_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  alu_seq_core #(.DATA_W(8)) dut (
    .clk_p_i  (clk),
    .reset_n_i(rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_a_i (a),
    .data_b_i (b),
    .inst_i   (inst),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    valid_i = 1'b1;
    inst    = op;
    a       = va;
    b       = vb;
  endtask

  task automatic test_reset();
    total++;
    if ({ready_o, valid_o, data_o, err_o} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: ready=%b valid=%b data=%h err=%b, want 1 0 0000 0",
               ready_o, valid_o, data_o, err_o);
    end
  endtask

  task automatic test_add();
    logic [15:0] exp;
`ifdef ALU_SAT_EN
    exp = 16'd255;
`else
    exp = 16'd300;
`endif
    drive(3'b000, 8'd200, 8'd100);
    tick();
    valid_i = 1'b0;
    total++;
    if ({valid_o, data_o, err_o} !== {1'b1, exp, 1'b0}) begin
      bad++;
      $display("FAIL add: valid=%b data=%h err=%b, want 1 %h 0", valid_o, data_o, err_o, exp);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || data_o !== exp) begin
      bad++;
      $display("FAIL add_hold: valid=%b data=%h, want 0 %h", valid_o, data_o, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
`ifdef ALU_SAT_EN
    exp1 = 16'h0000;
    exp2 = 16'd9;
`else
    exp1 = 16'hFFFE;
    exp2 = 16'd9;
`endif
    drive(3'b001, 8'd5, 8'd3);
    tick();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp1 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_sub: valid=%b data=%h ready=%b, want 1 %h 1", valid_o, data_o, ready_o, exp1);
    end
    drive(3'b111, 8'd1, 8'd10);
    tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || data_o !== exp2) begin
      bad++;
      $display("FAIL b2b_pre: valid=%b data=%h, want 1 %h", valid_o, data_o, exp2);
    end
  endtask

  task automatic test_misc_ops();
    logic [15:0] exp_sub;
`ifdef ALU_SAT_EN
    exp_sub = 16'd0;
`else
    exp_sub = 16'hFFFA;
`endif
    drive(3'b110, 8'd9, 8'd3);   // ABS 3-9
    tick();
    total++;
    if (data_o !== 16'd6) begin bad++; $display("FAIL abs: data=%h, want 0006", data_o); end
    drive(3'b001, 8'd9, 8'd3);   // SUB 3-9
    tick();
    total++;
    if (data_o !== exp_sub) begin bad++; $display("FAIL sub: data=%h, want %h", data_o, exp_sub); end
    drive(3'b010, 8'd200, 8'd100);
    tick();
    total++;
    if (data_o !== 16'h4E20) begin bad++; $display("FAIL mul: data=%h, want 4e20", data_o); end
    drive(3'b100, 8'd3, 8'd5);   // NOT ~(5-3)
    tick();
    total++;
    if (data_o !== 16'hFFFD) begin bad++; $display("FAIL not: data=%h, want fffd", data_o); end
    drive(3'b101, 8'hA5, 8'h0F);
    tick();
    valid_i = 1'b0;
    total++;
    if (data_o !== 16'h00AA || err_o !== 1'b0) begin
      bad++;
      $display("FAIL xor: data=%h err=%b, want 00aa 0", data_o, err_o);
    end
  endtask

  task automatic test_div();
    drive(3'b011, 8'd100, 8'd7);
    tick();
    valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
        bad++;
        $display("FAIL div_busy c%0d: ready=%b valid=%b, want 0 0", c, ready_o, valid_o);
      end
      tick();
    end
    total++;
    if ({valid_o, data_o, err_o, ready_o} !== {1'b1, 16'h020E, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL div_res: valid=%b data=%h err=%b ready=%b, want 1 020e 0 1",
               valid_o, data_o, err_o, ready_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || data_o !== 16'h020E) begin
      bad++;
      $display("FAIL div_hold: valid=%b data=%h, want 0 020e", valid_o, data_o);
    end
  endtask

  task automatic test_div_zero();
    int pulses;
    int n;
    logic seen;
    pulses = 0;
    drive(3'b011, 8'd55, 8'd0);
    tick();
    drive(3'b000, 8'd1, 8'd1);   // ignored while busy
    for (int c = 1; c <= 8; c++) begin
      if (valid_o) pulses++;
      if (c == 8) valid_i = 1'b0;
      tick();
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL dz_extra: pulses=%0d, want 0", pulses); end
    total++;
    if ({valid_o, data_o, err_o} !== {1'b1, 16'h37FF, 1'b1}) begin
      bad++;
      $display("FAIL dz_res: valid=%b data=%h err=%b, want 1 37ff 1", valid_o, data_o, err_o);
    end
    tick();
    // PRE must still replay DIV: the ignored ADDs never updated last_op
    drive(3'b111, 8'd20, 8'd3);
    tick();
    valid_i = 1'b0;
    n = 1;
    seen = valid_o;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = valid_o;
    end
    total++;
    if (!seen || n != 9 || data_o !== 16'h0206 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL pre_div: seen=%b lat=%0d data=%h err=%b, want 1 9 0206 0", seen, n, data_o, err_o);
    end
  endtask

  task automatic test_reset_mid_div();
    drive(3'b011, 8'd100, 8'd7);
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    test_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_pulse: valid=%b, want 0", valid_o); end
      if (c == 2) rst_n = 1'b1;
      if (c == 2) test_reset();
    end
    drive(3'b111, 8'd2, 8'd3);   // last_op back to ADD
    tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || data_o !== 16'd5) begin
      bad++;
      $display("FAIL rst_pre: valid=%b data=%h, want 1 0005", valid_o, data_o);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    inst    = 3'b000;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_add();
    test_back_to_back();
    test_misc_ops();
    test_div();
    test_div_zero();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
